// File: rtl/audio_pkg.sv
// Shared types and constants for the audio clip sequencer: default widths,
// effect-channel state encoding and saturation limit helpers.
package audio_pkg;

    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_ADDR_W   = 18;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } eff_state_t;

    // Two's-complement limits for a w-bit sample, returned in the low w bits.
    function automatic logic [31:0] sat_max(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_min(input int w);
        return 32'hFFFF_FFFF << (w - 1);
    endfunction

endpackage

// File: rtl/sat_mixer.sv
// Combinational signed two-input adder that clamps the result to the
// representable SAMPLE_W-bit range instead of wrapping.
module sat_mixer
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic signed [SAMPLE_W-1:0] a,
    input  logic signed [SAMPLE_W-1:0] b,
    output logic signed [SAMPLE_W-1:0] y
);

    localparam logic [SAMPLE_W-1:0] LIM_HI = SAMPLE_W'(sat_max(SAMPLE_W));
    localparam logic [SAMPLE_W-1:0] LIM_LO = SAMPLE_W'(sat_min(SAMPLE_W));

    logic signed [SAMPLE_W:0] sum;

    always_comb begin
        sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
        // Overflow shows up as the two top bits of the wide sum disagreeing.
        if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
            y = sum[SAMPLE_W] ? LIM_LO : LIM_HI;
        end else begin
            y = sum[SAMPLE_W-1:0];
        end
    end

endmodule

// File: rtl/audio_clip_sequencer.sv
// Frame-rate playback engine: looping music channel plus a one-shot effect
// channel, mixed with saturation. Define AUDIO_DUCK_EN to attenuate music during the effect.
module audio_clip_sequencer
    import audio_pkg::*;
#(
    parameter int         SAMPLE_W   = DEF_SAMPLE_W,
    parameter int         ADDR_W     = DEF_ADDR_W,
    parameter int         MUSIC_LEN  = 200001,
    parameter int         EFFECT_LEN = 200001,
    parameter logic [7:0] TRIG_CODE  = 8'h2C,
    parameter int         DUCK_SHIFT = 1
) (
    input  logic                DAC_LR_CLK,
    input  logic                reset,
    input  logic                enable,
    input  logic [7:0]          tripper,
    input  logic [SAMPLE_W-1:0] music_q,
    input  logic [SAMPLE_W-1:0] effect_q,
    output logic [ADDR_W-1:0]   music_addr,
    output logic [ADDR_W-1:0]   effect_addr,
    output logic                rden,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                effect_active
);

    if (DUCK_SHIFT < 0 || DUCK_SHIFT >= SAMPLE_W) begin : g_bad_shift
        $error("DUCK_SHIFT out of range for SAMPLE_W");
    end
    if (MUSIC_LEN > 2 ** ADDR_W || EFFECT_LEN > 2 ** ADDR_W) begin : g_bad_len
        $error("clip length does not fit in ADDR_W");
    end

    localparam logic [ADDR_W-1:0] MUSIC_LAST  = ADDR_W'(MUSIC_LEN - 1);
    localparam logic [ADDR_W-1:0] EFFECT_LAST = ADDR_W'(EFFECT_LEN - 1);

    eff_state_t                 state, state_next;
    logic [ADDR_W-1:0]          effect_addr_next;
    logic                       trig_prev;
    logic                       trig_event;
    logic                       eff_valid_d;
    logic signed [SAMPLE_W-1:0] music_term;
    logic signed [SAMPLE_W-1:0] effect_term;
    logic signed [SAMPLE_W-1:0] mixed;

    assign trig_event    = (tripper == TRIG_CODE) && !trig_prev;
    assign effect_active = (state == PLAY);

    always_comb begin
        state_next       = state;
        effect_addr_next = '0;
        unique case (state)
            IDLE: begin
                if (trig_event) state_next = PLAY;
            end
            PLAY: begin
                // A restart outranks end-of-clip on the same frame.
                if (trig_event) begin
                    state_next = PLAY;
                end else if (effect_addr == EFFECT_LAST) begin
                    state_next = IDLE;
                end else begin
                    effect_addr_next = effect_addr + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef AUDIO_DUCK_EN
    assign music_term = eff_valid_d ? ($signed(music_q) >>> DUCK_SHIFT) : $signed(music_q);
`else
    assign music_term = $signed(music_q);
`endif
    assign effect_term = eff_valid_d ? $signed(effect_q) : '0;

    sat_mixer #(.SAMPLE_W(SAMPLE_W)) u_mixer (
        .a (music_term),
        .b (effect_term),
        .y (mixed)
    );

    // NOTE: all state here is flops updated with <=; reset is sampled on the frame edge.
    always_ff @(posedge DAC_LR_CLK) begin
        if (!reset) begin
            state       <= IDLE;
            music_addr  <= '0;
            effect_addr <= '0;
            trig_prev   <= 1'b0;
            eff_valid_d <= 1'b0;
            rden        <= 1'b0;
            sample_out  <= '0;
        end else begin
            trig_prev <= (tripper == TRIG_CODE);
            rden      <= enable;
            if (enable) begin
                music_addr  <= (music_addr == MUSIC_LAST) ? '0 : music_addr + 1'b1;
                state       <= state_next;
                effect_addr <= effect_addr_next;
                eff_valid_d <= (state_next == PLAY);
                // ROM data is only meaningful once an address was issued with rden high.
                sample_out  <= rden ? mixed : '0;
            end else begin
                sample_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_audio_clip_sequencer.sv
// Directed, table-driven bench for audio_clip_sequencer with short clip
// lengths (music 8, effect 4) so wraps and end-of-clip are reached quickly.
module tb_audio_clip_sequencer;

    localparam int SW = 16;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [7:0]    tripper;
    logic [SW-1:0] music_q;
    logic [SW-1:0] effect_q;
    logic [AW-1:0] music_addr;
    logic [AW-1:0] effect_addr;
    logic          rden;
    logic [SW-1:0] sample_out;
    logic          effect_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_clip_sequencer #(
        .SAMPLE_W  (SW),
        .ADDR_W    (AW),
        .MUSIC_LEN (8),
        .EFFECT_LEN(4),
        .TRIG_CODE (8'h2C),
        .DUCK_SHIFT(1)
    ) dut (
        .DAC_LR_CLK   (clk),
        .reset        (reset),
        .enable       (enable),
        .tripper      (tripper),
        .music_q      (music_q),
        .effect_q     (effect_q),
        .music_addr   (music_addr),
        .effect_addr  (effect_addr),
        .rden         (rden),
        .sample_out   (sample_out),
        .effect_active(effect_active)
    );

    typedef struct {
        logic          en;
        logic [7:0]    trip;
        logic [SW-1:0] mq;
        logic [SW-1:0] eq;
        logic [AW-1:0] m_addr;
        logic [AW-1:0] e_addr;
        logic          rd;
        logic [SW-1:0] smp;
        logic          act;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

`ifdef AUDIO_DUCK_EN
    localparam logic [SW-1:0] NEG_SAT_EXP = 16'hB000;
`else
    localparam logic [SW-1:0] NEG_SAT_EXP = 16'h8000;
`endif

    function automatic vec_t mk(input logic en, input logic [7:0] trip,
                                input logic [SW-1:0] mq, input logic [SW-1:0] eq,
                                input int m, input int e, input logic rd,
                                input logic [SW-1:0] smp, input logic act);
        vec_t v;
        v.en = en; v.trip = trip; v.mq = mq; v.eq = eq;
        v.m_addr = AW'(m); v.e_addr = AW'(e); v.rd = rd; v.smp = smp; v.act = act;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int m, input int e, input logic rd,
                             input logic [SW-1:0] smp, input logic act);
        check({tag, " music_addr"},    32'(music_addr),    32'(m));
        check({tag, " effect_addr"},   32'(effect_addr),   32'(e));
        check({tag, " rden"},          32'(rden),          32'(rd));
        check({tag, " sample_out"},    32'(sample_out),    32'(smp));
        check({tag, " effect_active"}, 32'(effect_active), 32'(act));
    endtask

    initial begin
        // Music loop from reset, wrap 7->0, effect held-trigger, retrigger,
        // saturation in both directions, enable dropped mid-clip.
        vecs[0]  = mk(1, 8'h00, 16'h0100, 16'h0100, 1, 0, 1, 16'h0000, 0);
        vecs[1]  = mk(1, 8'h00, 16'h0100, 16'h0100, 2, 0, 1, 16'h0100, 0);
        vecs[2]  = mk(1, 8'h00, 16'h0100, 16'h0100, 3, 0, 1, 16'h0100, 0);
        vecs[3]  = mk(1, 8'h00, 16'h0100, 16'h0100, 4, 0, 1, 16'h0100, 0);
        vecs[4]  = mk(1, 8'h00, 16'h0100, 16'h0100, 5, 0, 1, 16'h0100, 0);
        vecs[5]  = mk(1, 8'h00, 16'h0100, 16'h0100, 6, 0, 1, 16'h0100, 0);
        vecs[6]  = mk(1, 8'h00, 16'h0100, 16'h0100, 7, 0, 1, 16'h0100, 0);
        vecs[7]  = mk(1, 8'h00, 16'h0100, 16'h0100, 0, 0, 1, 16'h0100, 0);
        vecs[8]  = mk(1, 8'h2C, 16'h0100, 16'h0100, 1, 0, 1, 16'h0100, 1);
        vecs[9]  = mk(1, 8'h2C, 16'h0100, 16'h0100, 2, 1, 1, 16'h0200, 1);
        vecs[10] = mk(1, 8'h2C, 16'h0100, 16'h0100, 3, 2, 1, 16'h0200, 1);
        vecs[11] = mk(1, 8'h2C, 16'h0100, 16'h0100, 4, 3, 1, 16'h0200, 1);
        vecs[12] = mk(1, 8'h2C, 16'h0100, 16'h0100, 5, 0, 1, 16'h0200, 0);
        vecs[13] = mk(1, 8'h2C, 16'h0100, 16'h0100, 6, 0, 1, 16'h0100, 0);
        vecs[14] = mk(1, 8'h2C, 16'h0100, 16'h0100, 7, 0, 1, 16'h0100, 0);
        vecs[15] = mk(1, 8'h2C, 16'h0100, 16'h0100, 0, 0, 1, 16'h0100, 0);
        vecs[16] = mk(1, 8'h2C, 16'h0100, 16'h0100, 1, 0, 1, 16'h0100, 0);
        vecs[17] = mk(1, 8'h2C, 16'h0100, 16'h0100, 2, 0, 1, 16'h0100, 0);
        vecs[18] = mk(1, 8'h00, 16'h0100, 16'h0100, 3, 0, 1, 16'h0100, 0);
        vecs[19] = mk(1, 8'h2C, 16'h0100, 16'h0100, 4, 0, 1, 16'h0100, 1);
        vecs[20] = mk(1, 8'h2C, 16'h0100, 16'h0100, 5, 1, 1, 16'h0200, 1);
        vecs[21] = mk(1, 8'h00, 16'h0100, 16'h0100, 6, 2, 1, 16'h0200, 1);
        vecs[22] = mk(1, 8'h2C, 16'h0100, 16'h0100, 7, 0, 1, 16'h0200, 1);
        vecs[23] = mk(1, 8'h2C, 16'h0100, 16'h0100, 0, 1, 1, 16'h0200, 1);
        vecs[24] = mk(1, 8'h2C, 16'h7000, 16'h7000, 1, 2, 1, 16'h7FFF, 1);
        vecs[25] = mk(1, 8'h2C, 16'h8000, 16'hF000, 2, 3, 1, NEG_SAT_EXP, 1);
        vecs[26] = mk(0, 8'h00, 16'h0100, 16'h0100, 2, 3, 0, 16'h0000, 1);
        vecs[27] = mk(0, 8'h00, 16'h0100, 16'h0100, 2, 3, 0, 16'h0000, 1);
        vecs[28] = mk(1, 8'h00, 16'h0100, 16'h0100, 3, 0, 1, 16'h0000, 0);
        vecs[29] = mk(1, 8'h00, 16'hFF00, 16'h0100, 4, 0, 1, 16'hFF00, 0);

        reset    = 1'b0;
        enable   = 1'b1;
        tripper  = 8'h2C;
        music_q  = 16'h0100;
        effect_q = 16'h0100;
        step();
        step();
        check_all("reset", 0, 0, 1'b0, 16'h0000, 1'b0);

        reset   = 1'b1;
        tripper = 8'h00;
        for (int i = 0; i < NV; i++) begin
            enable   = vecs[i].en;
            tripper  = vecs[i].trip;
            music_q  = vecs[i].mq;
            effect_q = vecs[i].eq;
            step();
            check_all($sformatf("vec%0d", i), int'(vecs[i].m_addr), int'(vecs[i].e_addr),
                      vecs[i].rd, vecs[i].smp, vecs[i].act);
        end

        // Reset in the middle of a clip aborts it; a new trigger re-arms.
        music_q  = 16'h0100;
        effect_q = 16'h0100;
        tripper  = 8'h2C;
        step();
        check("pre-reset effect_active", 32'(effect_active), 32'd1);
        step();
        check("pre-reset effect_addr", 32'(effect_addr), 32'd1);
        reset   = 1'b0;
        tripper = 8'h00;
        step();
        check_all("midclip_reset", 0, 0, 1'b0, 16'h0000, 1'b0);
        reset = 1'b1;
        step();
        check_all("post_reset", 1, 0, 1'b1, 16'h0000, 1'b0);
        tripper = 8'h2C;
        step();
        check_all("rearm", 2, 0, 1'b1, 16'h0100, 1'b1);
        step();
        check_all("rearm_play", 3, 1, 1'b1, 16'h0200, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_clip_sequencer.md
# audio_clip_sequencer

Frame-rate playback engine for the WM8731 audio path. It replaces the single shared ROM address counter with two independent channels. A free-running background-music loop is mixed with a one-shot sound effect, which is started by a trigger code on `tripper`. The block runs on `DAC_LR_CLK`, drives both sample ROMs' address and read-enable inputs, and hands one saturated signed mixed sample per frame to the BCLK-domain serializer.

## Interface
- `SAMPLE_W`, 16: sample width (signed, two's complement).
- `ADDR_W`, 18: ROM address width.
- `MUSIC_LEN`, 200001: music clip length in samples; addresses run 0..MUSIC_LEN-1.
- `EFFECT_LEN`, 200001: effect clip length in samples.
- `TRIG_CODE`, 8'h2C: `tripper` value that fires the effect.
- `DUCK_SHIFT`, 1: right-shift applied to music while the effect plays (only with `AUDIO_DUCK_EN`).

Ports:
- `DAC_LR_CLK`, in, 1: frame clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-low.
- `enable`, in, 1: codec configuration complete; playback runs only while high.
- `tripper`, in, 8: trigger code from the game logic, stable for at least one frame.
- `music_q`, in, SAMPLE_W: music ROM data.
- `effect_q`, in, SAMPLE_W: effect ROM data.
- `music_addr`, out, ADDR_W: music ROM address.
- `effect_addr`, out, ADDR_W: effect ROM address.
- `rden`, out, 1: ROM read enable for both ROMs.
- `sample_out`, out, SAMPLE_W: mixed sample for the serializer.
- `effect_active`, out, 1: high while the effect FSM is in PLAY.

## Operation
- Reset (`reset`=0 at an edge):
  - `music_addr`, `effect_addr` and `sample_out` are 0.
  - `rden`=0, `effect_active`=0.
  - Effect FSM goes to IDLE and the trigger history register is cleared.
- `enable`=0:
  - Both address counters and the FSM hold their values.
  - `rden`=0 and `sample_out`=0 (silence).
  - The trigger history still updates every frame.
- `enable`=1:
  - `rden`=1.
  - Music counter increments every frame and wraps from MUSIC_LEN-1 to 0.
- Trigger event: `tripper`==TRIG_CODE this frame and `tripper`!=TRIG_CODE in the previous frame (rising match only). Holding the code does not refire.
- Effect FSM:
  - IDLE: `effect_addr`=0. On a trigger event, go to PLAY with `effect_addr`=0.
  - PLAY: `effect_addr` increments each frame. At EFFECT_LEN-1, the next frame returns to IDLE with `effect_addr`=0.
  - Trigger event in PLAY: restart, with `effect_addr`=0 and the state staying PLAY.
  - Trigger event on the same frame as end-of-clip: the restart wins.
- `eff_valid_d`: registered copy of (state==PLAY) for the address presented last frame. It aligns effect data with the frame that requested it.
- Mixing:
  - sum = music_term + (eff_valid_d ? effect_q : 0), computed at SAMPLE_W+1 bits signed.
  - The sum saturates to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - The saturated result is registered into `sample_out`.

## Timing
- Addresses update at frame edge n.
- The ROMs (clk domain, 1-clk latency) return data long before edge n+1.
- `sample_out` for the address issued at edge n is registered at edge n+1, a latency of 1 frame. The serializer shifts it during frame n+1.
- First valid `sample_out` after `enable` rises: second frame edge with `enable`=1.
- `effect_active` rises on the edge after the trigger frame and falls on the edge after address EFFECT_LEN-1.
- Reset mid-clip aborts the effect immediately. Re-arm then requires a fresh trigger event.

## Configuration
- `AUDIO_DUCK_EN` defined: music_term = music_q >>> DUCK_SHIFT (arithmetic shift) whenever `eff_valid_d`=1, otherwise music_q.
- `AUDIO_DUCK_EN` undefined: music_term = music_q always. `DUCK_SHIFT` is unused.

## Structure
- Shared package `audio_pkg`:
  - `SAMPLE_W` and `ADDR_W` defaults.
  - Effect state enum {IDLE, PLAY}.
  - Saturation limit constants.
- Sub-module `sat_mixer`: signed two-input add with saturation, parametrised by SAMPLE_W, combinational.

## Test plan
- Reset then `enable`=1, music_q=16'h0100 constant, effect_q=16'h0100 constant → music_addr counts 0,1,2…; sample_out=16'h0100 from the second frame; effect_addr=0; effect_active=0.
- MUSIC_LEN=8 → music_addr sequence …,6,7,0,1.
- EFFECT_LEN=4 with `tripper`=8'h2C held for 10 frames:
  - effect_active is high for exactly 4 frames.
  - effect_addr runs 0,1,2,3 then 0.
  - There is no refire.
- Retrigger: tripper goes 8'h2C, 8'h00, 8'h2C while effect_addr=2 → effect_addr returns to 0 and effect_active stays 1.
- Saturation:
  - music_q=16'h7000 and effect_q=16'h7000 during PLAY: sample_out=16'h7FFF without the macro, 16'h7FFF with the macro and DUCK_SHIFT=1.
  - music_q=16'h8000 and effect_q=16'hF000: sample_out=16'h8000 without the macro, 16'hB000 with the macro.
- `enable` dropped mid-clip → rden=0, sample_out=0, addresses frozen; playback resumes from the frozen addresses when `enable` returns.
